fft_frame_sequencer: RTL

Frame-level controller for the WISHBONE_FFT datapath. Sequences one N-point radix-2 transform through three phases: sample load, per-stage butterfly scheduling, and result unload. Drives the address/index counters and enables that the sample RAM, butterfly unit and twiddle ROM consume. Sits between the Wishbone slave register front end (start/abort, status) and the FFT core memories.

---
 rtl/fft_frame_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//
// Frame-level controller for the WISHBONE_FFT datapath. Sequences one
// N-point (N = 2**LOG2N) radix-2 transform through sample load, per-stage
// butterfly scheduling (with a BFLY_LAT idle gap after each stage) and
// result unload.
//
// Optional feature macro: FFT_SEQ_BITREV_EN
//   defined   : out_addr is the bit-reversed unload counter
//   undefined : out_addr is the unload counter itself
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   start      begin a frame (honoured only in IDLE)
//   abort      synchronous return to IDLE from any state
//   in_valid   input sample present
//   in_ready   sequencer accepts a sample (LOAD only)
//   load_addr  sample RAM write address
//   bfly_en    butterfly issue strobe
//   stage      current stage, 0..LOG2N-1
//   bfly_idx   butterfly index within stage, 0..N/2-1
//   out_valid  result available (UNLOAD only)
//   out_ready  downstream accepts result
//   out_addr   sample RAM read address for unload
//   busy       high in every state except IDLE
//   done       one-cycle pulse on frame completion
module fft_frame_sequencer #(
    parameter int unsigned LOG2N    = 3,
    parameter int unsigned BFLY_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [LOG2N-1:0]         load_addr,
    output logic                     bfly_en,
    output logic [$clog2(LOG2N):0]   stage,
    output logic [LOG2N-2:0]         bfly_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LOG2N-1:0]         out_addr,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned STW = $clog2(LOG2N) + 1;

    localparam logic [LOG2N-1:0] LAST_ADDR  = '1;
    localparam logic [LOG2N-2:0] LAST_IDX   = '1;
    localparam logic [STW-1:0]   LAST_STAGE = STW'(LOG2N - 1);
    // Only meaningful when BFLY_LAT > 0; the GAP state is unreachable otherwise.
    localparam logic [3:0]       GAP_LAST   = 4'(BFLY_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        GAP,
        UNLOAD
    } state_t;

    state_t            state, state_nxt;
    logic [LOG2N-1:0]  load_nxt;
    logic [STW-1:0]    stage_nxt;
    logic [LOG2N-2:0]  idx_nxt;
    logic [3:0]        gap_cnt, gap_nxt;
    logic [LOG2N-1:0]  unload_cnt, unload_nxt;
    logic              done_nxt;
    logic              stage_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            load_addr  <= '0;
            stage      <= '0;
            bfly_idx   <= '0;
            gap_cnt    <= '0;
            unload_cnt <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_addr  <= load_nxt;
            stage      <= stage_nxt;
            bfly_idx   <= idx_nxt;
            gap_cnt    <= gap_nxt;
            unload_cnt <= unload_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_nxt   = load_addr;
        stage_nxt  = stage;
        idx_nxt    = bfly_idx;
        gap_nxt    = gap_cnt;
        unload_nxt = unload_cnt;
        done_nxt   = 1'b0;
        stage_end  = 1'b0;
        in_ready   = 1'b0;
        bfly_en    = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_nxt = load_addr + LOG2N'(1);
                    if (load_addr == LAST_ADDR) begin
                        state_nxt = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                bfly_en = 1'b1;
                idx_nxt = bfly_idx + (LOG2N - 1)'(1);
                if (bfly_idx == LAST_IDX) begin
                    if (BFLY_LAT > 0) begin
                        state_nxt = GAP;
                    end else begin
                        stage_end = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_nxt = gap_cnt + 4'd1;
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt   = '0;
                    stage_end = 1'b1;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    unload_nxt = unload_cnt + LOG2N'(1);
                    if (unload_cnt == LAST_ADDR) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Stage-end handling is shared between the last GAP cycle and, when
        // there is no gap, the last COMPUTE cycle of a stage.
        if (stage_end) begin
            if (stage == LAST_STAGE) begin
                stage_nxt = '0;
                state_nxt = UNLOAD;
            end else begin
                stage_nxt = stage + STW'(1);
                state_nxt = COMPUTE;
            end
        end

        // abort wins over start and over a final unload transfer.
        if (abort) begin
            state_nxt  = IDLE;
            load_nxt   = '0;
            stage_nxt  = '0;
            idx_nxt    = '0;
            gap_nxt    = '0;
            unload_nxt = '0;
            done_nxt   = 1'b0;
        end
    end

`ifdef FFT_SEQ_BITREV_EN
    always_comb begin
        out_addr = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            out_addr[i] = unload_cnt[LOG2N-1-i];
        end
    end
`else
    always_comb begin
        out_addr = unload_cnt;
    end
`endif

endmodule
